tdm_mux_8_1: RTL and testbench

Time-division multiplexing transmitter for the 8-channel demultiplexed links. It accepts one frame holding a sample for each of 8 channels through a valid/ready handshake and emits the samples one per clock on a single lane. Each sample goes out with its 3-bit slot index, so the `s`/`y` pair drives the 1-to-8 demux select and data inputs directly. A one-frame shadow buffer lets back-to-back frames stream with no idle cycles.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_mux_8_1.sv | 110 +++++++++++
 tb/tb_tdm_mux_8_1.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM transmit and receive sides.
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } tdm_state_e;

endpackage

// File: rtl/tdm_mux_8_1.sv
// 8:1 TDM transmitter: a one-frame shadow buffer feeds an active frame
// that is serialised one channel sample per clock with its slot index.
module tdm_mux_8_1
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] d,
    input  logic                    d_valid,
    output logic                    d_ready,
    output logic [WIDTH-1:0]        y,
    output logic [SEL_W-1:0]        s,
    output logic                    y_valid,
    output logic                    sof
);

    tdm_state_e              state;
    logic [SEL_W-1:0]        slot;
    logic [SEL_W-1:0]        slot_inc;
    logic [NUM_CH*WIDTH-1:0] shadow;
    logic [NUM_CH*WIDTH-1:0] active;
    logic                    shadow_full;
    logic                    accept;
    logic [WIDTH-1:0]        next_sample;

    assign d_ready  = !shadow_full;
    assign accept   = d_valid && !shadow_full;
    assign slot_inc = slot + 1'b1;

    // Outputs are registered, so pick the sample for the slot being entered.
    always_comb begin
        next_sample = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (slot_inc == SEL_W'(k)) begin
                next_sample = active[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
            y           <= '0;
            s           <= '0;
            y_valid     <= 1'b0;
            sof         <= 1'b0;
        end else begin
            // Accept and shadow->active move are exclusive: one needs the
            // shadow empty, the other needs it full.
            if (accept) begin
                shadow      <= d;
                shadow_full <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (shadow_full) begin
                        state       <= SEND;
                        active      <= shadow;
                        shadow_full <= 1'b0;
                        slot        <= '0;
                        y           <= shadow[0 +: WIDTH];
                        s           <= '0;
                        y_valid     <= 1'b1;
                        sof         <= 1'b1;
                    end else begin
                        y       <= '0;
                        s       <= '0;
                        y_valid <= 1'b0;
                        sof     <= 1'b0;
                    end
                end
                SEND: begin
                    if (slot != LAST_SLOT) begin
                        slot    <= slot_inc;
                        y       <= next_sample;
                        s       <= slot_inc;
                        y_valid <= 1'b1;
                        sof     <= 1'b0;
                    end else if (shadow_full) begin
                        active      <= shadow;
                        shadow_full <= 1'b0;
                        slot        <= '0;
                        y           <= shadow[0 +: WIDTH];
                        s           <= '0;
                        y_valid     <= 1'b1;
                        sof         <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        slot    <= '0;
                        y       <= '0;
                        s       <= '0;
                        y_valid <= 1'b0;
                        sof     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Scoreboard bench for tdm_mux_8_1 (WIDTH = 4): accepted frames expand into
// expected slots; a negedge monitor pops and compares, including demux loopback.
module tb_tdm_mux_8_1;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*W-1:0] d;
    logic           d_valid;
    logic           d_ready;
    logic [W-1:0]   y;
    logic [2:0]     s;
    logic           y_valid;
    logic           sof;

    always #5 clk = ~clk;

    tdm_mux_8_1 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .y       (y),
        .s       (s),
        .y_valid (y_valid),
        .sof     (sof)
    );

    typedef struct {
        logic [2:0]   s;
        logic [W-1:0] y;
        logic         sof;
    } slot_t;

    slot_t exp_q[$];
    int    pending  = 0;
    int    acc_cnt  = 0;
    int    cyc      = 0;
    int    acc_cyc  = 0;
    int    sof_cyc  = 0;
    int    cur_run  = 0;
    int    last_run = 0;
    int    tests    = 0;
    int    fails    = 0;
    bit    mon_en   = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Receive-side 1-to-8 demux: lane sel carries v, all other lanes are zero.
    function automatic logic [8*W-1:0] demux(logic [2:0] sel, logic [W-1:0] v);
        logic [8*W-1:0] r;
        r = '0;
        r[sel*W +: W] = v;
        return r;
    endfunction

    // Reference model: a frame is taken whenever no accepted frame is still
    // waiting to start; each accepted frame becomes 8 expected slots.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            pending = 0;
            mon_en  = 1'b1;
        end else if (d_valid && pending == 0) begin
            for (int k = 0; k < 8; k++) begin
                slot_t e;
                e.s   = 3'(k);
                e.y   = d[k*W +: W];
                e.sof = (k == 0);
                exp_q.push_back(e);
            end
            pending++;
            acc_cnt++;
            acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (y_valid) begin
                cur_run++;
                if (exp_q.size() == 0) begin
                    check("spurious y_valid", {31'd0, y_valid}, 32'd0);
                end else begin
                    slot_t e;
                    e = exp_q.pop_front();
                    check("slot s", {29'd0, s}, {29'd0, e.s});
                    check("sof", {31'd0, sof}, {31'd0, e.sof});
                    check("demux lanes", demux(s, y), demux(e.s, e.y));
                    if (e.sof) begin
                        pending--;
                        sof_cyc = cyc;
                    end
                end
            end else begin
                if (cur_run != 0) last_run = cur_run;
                cur_run = 0;
                check("idle outputs", {24'd0, y, s, sof}, 32'd0);
            end
            check("d_ready", {31'd0, d_ready}, {31'd0, pending == 0});
        end
    end

    task automatic accept_frame(input logic [8*W-1:0] f);
        int  start;
        bit  done;
        d       = f;
        d_valid = 1'b1;
        start   = acc_cnt;
        done    = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) done = 1'b1;
        end
        if (!done) check("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !y_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        check("drain queue empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        bit seen;
        rst     = 1'b1;
        d_valid = 1'b0;
        d       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Isolated frame: channel samples 0,1,1,0,0,1,0,1.
        accept_frame(32'h1010_0110);
        d_valid = 1'b0;
        drain();
        check("latency accept->sof", sof_cyc - acc_cyc, 32'd1);
        check("isolated run", last_run, 32'd8);

        // Three frames with d_valid held: backpressure, then gapless reloads.
        accept_frame(32'hFFFF_FFFF);
        accept_frame(32'h0000_0000);
        accept_frame(32'h7654_3210);
        d_valid = 1'b0;
        drain();
        check("gapless run", last_run, 32'd24);

        // Reset pulse at slot 3 discards the rest of the frame.
        accept_frame(32'hA5C3_9E17);
        d_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (y_valid && s == 3'd3) seen = 1'b1;
        end
        if (!seen) check("slot 3 timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("run cut by reset", last_run, 32'd4);
        accept_frame(32'h1357_9BDF);
        d_valid = 1'b0;
        drain();
        check("run after reset", last_run, 32'd8);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst     = ($urandom_range(0, 63) == 0);
            d_valid = ($urandom_range(0, 2) != 0);
            d       = $urandom;
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        d_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
